// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions.
// Holds the default register-file geometry and the state encoding of the
// register-file clear engine.
package cpu_pkg;

  localparam int CPU_DATA_W = 8;
  localparam int CPU_ADDR_W = 3;

  typedef enum logic [1:0] {
    RF_IDLE  = 2'd0,
    RF_CLEAR = 2'd1,
    RF_DONE  = 2'd2
  } rf_clr_state_t;

endpackage

// File: rtl/rf_clear_fsm.sv
// Sequential clear engine for the register file.
// Walks the array one entry per cycle after clr_req is seen in IDLE, then
// pulses clr_done for one cycle and returns to IDLE.
// Ports:
//   clk, reset_n        clock / async active-low reset
//   clr_req             start request, only honoured in IDLE
//   clr_busy            high in CLEAR and DONE
//   clr_done            one-cycle pulse in DONE
//   clr_stb             array should zero entry clr_idx this cycle
//   clr_idx             entry being cleared
module rf_clear_fsm import cpu_pkg::*; #(
  parameter int ADDR_W = CPU_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              clr_stb,
  output logic [ADDR_W-1:0] clr_idx
);

  localparam int DEPTH = 1 << ADDR_W;
  // One extra bit so the counter reaches DEPTH instead of wrapping to 0.
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH-1);

  rf_clr_state_t   state_q, state_d;
  logic [ADDR_W:0] idx_q, idx_d;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RF_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      RF_IDLE: begin
        if (clr_req) begin
          state_d = RF_CLEAR;
          idx_d   = '0;
        end
      end
      RF_CLEAR: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) state_d = RF_DONE;
      end
      RF_DONE: state_d = RF_IDLE;
      default: state_d = RF_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    clr_busy = 1'b0;
    clr_done = 1'b0;
    clr_stb  = 1'b0;
    case (state_q)
      RF_CLEAR: begin
        clr_busy = 1'b1;
        clr_stb  = 1'b1;
      end
      RF_DONE: begin
        clr_busy = 1'b1;
        clr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign clr_idx = idx_q[ADDR_W-1:0];

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: two combinational read ports, one write port
// with optional same-cycle bypass, an accumulator tap, per-entry valid bits
// and a one-entry-per-cycle clear engine.
// Ports:
//   clk, reset_n                 clock / async active-low reset
//   wr_en, wr_addr, wr_data      write port (ignored while clr_busy)
//   rd_a_addr/rd_a_data          read port A
//   rd_b_addr/rd_b_data          read port B
//   acc_out                      contents of register ACC_IDX
//   valid_out                    bit i set once entry i is written
//   clr_req, clr_busy, clr_done  clear engine control / status
module register_file_mp import cpu_pkg::*; #(
  parameter int DATA_W  = CPU_DATA_W,
  parameter int ADDR_W  = CPU_ADDR_W,
  parameter int ACC_IDX = (1 << ADDR_W) - 1,
  parameter bit BYPASS  = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [ADDR_W-1:0]        rd_a_addr,
  output logic [DATA_W-1:0]        rd_a_data,
  input  logic [ADDR_W-1:0]        rd_b_addr,
  output logic [DATA_W-1:0]        rd_b_data,
  output logic [DATA_W-1:0]        acc_out,
  output logic [(1<<ADDR_W)-1:0]   valid_out,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ACC_A = ACC_IDX[ADDR_W-1:0];

  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic [DEPTH-1:0]             valid;
  logic                         clr_stb;
  logic [ADDR_W-1:0]            clr_idx;
  logic                         wr_ok;
  logic                         byp;

  rf_clear_fsm #(.ADDR_W(ADDR_W)) u_clr (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .clr_stb  (clr_stb),
    .clr_idx  (clr_idx)
  );

  // Writes only land while the clear engine is idle; the same gate
  // enables forwarding so a dropped write is never seen on a read port.
  assign wr_ok = wr_en & ~clr_busy;
  assign byp   = BYPASS & wr_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs  <= '0;
      valid <= '0;
    end else if (clr_stb) begin
      regs[clr_idx]  <= '0;
      valid[clr_idx] <= 1'b0;
    end else if (wr_ok) begin
      regs[wr_addr]  <= wr_data;
      valid[wr_addr] <= 1'b1;
    end
  end

  always_comb begin
    rd_a_data = regs[rd_a_addr];
    rd_b_data = regs[rd_b_addr];
    acc_out   = regs[ACC_A];
    if (byp && rd_a_addr == wr_addr) rd_a_data = wr_data;
    if (byp && rd_b_addr == wr_addr) rd_b_data = wr_data;
    if (byp && ACC_A == wr_addr)     acc_out   = wr_data;
  end

  assign valid_out = valid;

endmodule

// File: tb/tb_register_file_mp.sv
module tb_register_file_mp;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [2:0] rd_a_addr = '0;
  logic [2:0] rd_b_addr = '0;
  logic       clr_req = 1'b0;

  logic [7:0] a1, b1, acc1, a0, b0, acc0;
  logic [7:0] v1, v0;
  logic       busy1, done1, busy0, done0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: plain array + cycles of busy window remaining.
  logic [7:0] m_mem [DEPTH] = '{default: 8'h00};
  logic [7:0] m_valid = '0;
  int         busy_left = 0;

  register_file_mp #(.DATA_W(8), .ADDR_W(3), .ACC_IDX(7), .BYPASS(1'b1)) u_dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_a_addr(rd_a_addr), .rd_a_data(a1), .rd_b_addr(rd_b_addr), .rd_b_data(b1),
    .acc_out(acc1), .valid_out(v1), .clr_req(clr_req), .clr_busy(busy1), .clr_done(done1)
  );

  register_file_mp #(.DATA_W(8), .ADDR_W(3), .ACC_IDX(7), .BYPASS(1'b0)) u_dut_nb (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_a_addr(rd_a_addr), .rd_a_data(a0), .rd_b_addr(rd_b_addr), .rd_b_data(b0),
    .acc_out(acc0), .valid_out(v0), .clr_req(clr_req), .clr_busy(busy0), .clr_done(done0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: busy window is DEPTH+1 cycles; its first DEPTH cycles zero
  // entries 0..DEPTH-1 in order, the last is the done cycle.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] <= 8'h00;
      m_valid   <= '0;
      busy_left <= 0;
    end else if (busy_left > 0) begin
      if (DEPTH + 1 - busy_left < DEPTH) begin
        m_mem[DEPTH + 1 - busy_left]   <= 8'h00;
        m_valid[DEPTH + 1 - busy_left] <= 1'b0;
      end
      busy_left <= busy_left - 1;
    end else begin
      if (wr_en) begin
        m_mem[wr_addr]   <= wr_data;
        m_valid[wr_addr] <= 1'b1;
      end
      if (clr_req) busy_left <= DEPTH + 1;
    end
  end

  // Compare process: every cycle, mid-period.
  always @(negedge clk) begin
    logic       fwd;
    logic [7:0] ea, eb, eacc;
    fwd  = wr_en && (busy_left == 0);
    ea   = (fwd && rd_a_addr == wr_addr) ? wr_data : m_mem[rd_a_addr];
    eb   = (fwd && rd_b_addr == wr_addr) ? wr_data : m_mem[rd_b_addr];
    eacc = (fwd && wr_addr == 3'd7)      ? wr_data : m_mem[7];
    chk("byp_rd_a", a1, ea);
    chk("byp_rd_b", b1, eb);
    chk("byp_acc", acc1, eacc);
    chk("byp_valid", v1, m_valid);
    chk("byp_busy", busy1, busy_left > 0);
    chk("byp_done", done1, busy_left == 1);
    chk("nb_rd_a", a0, m_mem[rd_a_addr]);
    chk("nb_rd_b", b0, m_mem[rd_b_addr]);
    chk("nb_acc", acc0, m_mem[7]);
    chk("nb_valid", v0, m_valid);
    chk("nb_busy", busy0, busy_left > 0);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill;
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 8'((i + 1) * 17);
      tick();
    end
    wr_en = 1'b0;
  endtask

  initial begin
    int nb, nd;
    #1 reset_n = 1'b0;
    #3;
    chk("rst_valid", v1, 8'h00);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_done", done1, 1'b0);
    chk("rst_acc", acc1, 8'h00);
    #8 reset_n = 1'b1;   // t=12, away from edges
    tick();

    // Write 0x5A to r3, read next cycle
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'h5A; rd_a_addr = 3'd3;
    #1 chk("wr_nb_before", a0, 8'h00);
    tick(); wr_en = 1'b0;
    #1;
    chk("wr_r3_rd_a", a0, 8'h5A);
    chk("wr_r3_valid", v1, 8'h08);

    // Bypass to r7
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 8'hC3; rd_b_addr = 3'd7;
    #1;
    chk("byp_rd_b_lit", b1, 8'hC3);
    chk("byp_acc_lit", acc1, 8'hC3);
    chk("nb_rd_b_old", b0, 8'h00);
    chk("nb_acc_old", acc0, 8'h00);
    tick(); wr_en = 1'b0;
    #1 chk("nb_rd_b_new", b0, 8'hC3);

    // Full clear with write attempt to r2 in the middle
    fill();
    rd_a_addr = 3'd0; rd_b_addr = 3'd1;
    #1 chk("fill_valid", v1, 8'hFF);
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    nb = 0; nd = 0;
    for (int j = 0; j < 12; j++) begin
      if (j == 3) begin wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'hFF; end
      if (j == 4) wr_en = 1'b0;
      #1;
      if (j == 1) begin chk("clr_r0_zero", a1, 8'h00); chk("clr_r1_kept", b1, 8'h22); end
      if (j == 2) chk("clr_r1_zero", b1, 8'h00);
      nb += int'(busy1); nd += int'(done1);
      tick();
    end
    chk("clr_busy_cycles", nb, 9);
    chk("clr_done_pulses", nd, 1);
    chk("clr_valid_zero", v1, 8'h00);
    rd_a_addr = 3'd2;
    #1 chk("clr_r2_ignored", a1, 8'h00);

    // Reset in the middle of a clear, at idx = 4
    fill();
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    repeat (4) tick();
    #2 reset_n = 1'b0;
    #1;
    chk("abort_busy", busy1, 1'b0);
    chk("abort_valid", v1, 8'h00);
    chk("abort_acc", acc1, 8'h00);
    #3 reset_n = 1'b1;
    nd = 0;
    for (int j = 0; j < 12; j++) begin
      tick(); nd += int'(done1);
    end
    chk("abort_no_done", nd, 0);

    // clr_req held through the busy window
    fill();
    clr_req = 1'b1; tick();
    nb = 0; nd = 0;
    for (int j = 0; j < 14; j++) begin
      nb += int'(busy1); nd += int'(done1);
      if (j == 8) clr_req = 1'b0;
      tick();
    end
    chk("held_busy_cycles", nb, 9);
    chk("held_done_pulses", nd, 1);

    // Random traffic
    for (int j = 0; j < 400; j++) begin
      wr_en     = ($urandom_range(0, 2) != 0);
      wr_addr   = 3'($urandom);
      wr_data   = 8'($urandom);
      rd_a_addr = 3'($urandom);
      rd_b_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom);
      clr_req   = ($urandom_range(0, 39) == 0);
      tick();
    end
    wr_en = 1'b0; clr_req = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port register file, successor to the CPU's single-read-port file. Provides two combinational read ports, one write port with optional write-to-read bypass, and a dedicated accumulator tap. Adds per-register valid tracking and a sequential clear engine that scrubs the array one entry per cycle without a global reset. Sits between decode (read addresses) and writeback (write port) in the 8-bit datapath.

## Interface
- DATA_W, 8, register width in bits
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries
- ACC_IDX, DEPTH-1, index of the accumulator register
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports and acc_out; 0 = no forwarding
- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write index
- wr_data  in  DATA_W  write data
- rd_a_addr  in  ADDR_W  read port A index
- rd_a_data  out  DATA_W  read port A data
- rd_b_addr  in  ADDR_W  read port B index
- rd_b_data  out  DATA_W  read port B data
- acc_out  out  DATA_W  contents of register ACC_IDX
- valid_out  out  DEPTH  bit i = 1: register i written since the last reset or clear
- clr_req  in  1  start-clear request, sampled when idle
- clr_busy  out  1  clear in progress; writes ignored
- clr_done  out  1  one-cycle pulse when a clear completes

## Operation
- Reset (reset_n low, asynchronous): all registers 0, valid_out 0, FSM IDLE, clr_busy 0, clr_done 0, clear index 0.
- Write: in IDLE, when wr_en = 1, registers[wr_addr] <= wr_data and valid[wr_addr] <= 1 at the next edge.
- Reads: rd_a_data, rd_b_data and acc_out are combinational views of the array.
- Bypass (BYPASS = 1): if wr_en = 1, the FSM is IDLE and a port's address equals wr_addr, that port (and acc_out when wr_addr = ACC_IDX) outputs wr_data in the same cycle.
- Both read ports may address the same entry; both return the same value.
- FSM states:
  - IDLE: clr_req = 1 moves to CLEAR and sets the index to 0. A wr_en in the same cycle is still committed; the clear later zeroes it.
  - CLEAR: each cycle, registers[idx] <= 0 and valid[idx] <= 0, then idx increments. After idx = DEPTH-1 the FSM moves to DONE.
  - DONE: clr_done = 1 for one cycle, then the FSM returns to IDLE.
- clr_busy = 1 in CLEAR and DONE.
- While busy:
  - wr_en is ignored (no array or valid update).
  - Bypass is disabled.
  - clr_req is ignored.
  - Reads return current array contents, partially cleared.
- Index counter is ADDR_W+1 bits so terminal detection does not wrap.
- Asserting reset_n low mid-clear aborts the clear: reset state applies immediately and no clr_done pulse is produced.

## Timing
- Write to read visibility: next cycle through the array; same cycle when bypass is active.
- Clear latency: clr_req sampled at edge N; entries are zeroed at edges N+1 through N+DEPTH. clr_done is high in the cycle after the last entry is zeroed. The first wr_en accepted is at edge N+DEPTH+2.
- Total busy window: DEPTH+1 cycles (DEPTH = 8 gives 9 cycles).
- All state changes occur on the rising edge of clk, except reset, which is asynchronous.

## Structure
- Shared package cpu_pkg holds:
  - DATA_W and ADDR_W defaults
  - clear FSM state encoding rf_clr_state_t (IDLE = 0, CLEAR = 1, DONE = 2)
- Sub-module rf_clear_fsm holds the state register, index counter, clr_busy and clr_done. It exports a clear strobe and index to the array.
- Array, valid bits, write logic and bypass muxes live in register_file_mp.

## Test plan
- Reset, then write 0x5A to r3; read A = 3 next cycle -> rd_a_data = 0x5A and valid_out = 0x08.
- BYPASS = 1: wr_en with addr 7, data 0xC3; rd_b_addr = 7 in the same cycle -> rd_b_data = 0xC3 and acc_out = 0xC3 before the edge.
- BYPASS = 0, same stimulus -> rd_b_data keeps the old value until the next cycle.
- Fill all 8 registers with 0x11..0x88; pulse clr_req -> clr_busy high for 9 cycles; r0..r7 zeroed on successive edges; clr_done pulses once; valid_out = 0.
- During clear, wr_en to r2 with 0xFF -> ignored; r2 reads 0 after the clear.
- Drop reset_n mid-clear at idx = 4 -> all registers 0, FSM IDLE, no clr_done pulse.
- clr_req held high during busy -> no second clear starts.
